// File: rtl/shift_frame_sequencer_if.sv
// Word handshake between a producer (grouper/packer) and the shift-frame sequencer.
interface shift_frame_sequencer_if #(
  parameter int unsigned WORD_WIDTH = 16
);
  logic                  start;
  logic [WORD_WIDTH-1:0] wordIn;
  logic                  abort;
  logic                  ready;
  logic                  busy;

  modport master (
    output start,
    output wordIn,
    output abort,
    input  ready,
    input  busy
  );

  modport slave (
    input  start,
    input  wordIn,
    input  abort,
    output ready,
    output busy
  );
endinterface

// File: rtl/shift_frame_sequencer.sv
// Serializes one word through an external right-shifting register: one parallel load,
// then WORD_WIDTH bitTick-paced shift strobes, qualifying each bit the register emits.
module shift_frame_sequencer #(
  parameter int unsigned WORD_WIDTH  = 16,
  parameter int unsigned COUNT_WIDTH = 4,
  parameter bit          MSB_FIRST   = 1'b0,
  parameter bit          FILL_BIT    = 1'b0
) (
  input  logic                   clock,
  input  logic                   resetN,
  shift_frame_sequencer_if.slave word_if,
  input  logic                   bitTick,
  output logic                   srEnable,
  output logic                   srLoadParallelly,
  output logic [WORD_WIDTH-1:0]  srParallelLoad,
  output logic                   srShiftRight,
  output logic                   srSerialLoad,
  input  logic                   srSerialOutput,
  output logic                   bitOut,
  output logic                   bitValid,
  output logic [COUNT_WIDTH-1:0] bitIndex,
  output logic                   frameDone
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  localparam logic [COUNT_WIDTH-1:0] LastCount = COUNT_WIDTH'(WORD_WIDTH - 1);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [WORD_WIDTH-1:0]  word_q, word_d;
  logic                   bit_valid_q, bit_valid_d;
  logic [COUNT_WIDTH-1:0] bit_index_q, bit_index_d;
  logic                   frame_done_q, frame_done_d;
  logic [WORD_WIDTH-1:0]  word_ordered;
  logic                   shift_strobe;

  // Reversing on capture lets a right-shifting register emit the MSB first.
  for (genvar i = 0; i < WORD_WIDTH; i++) begin : g_order
    assign word_ordered[i] = MSB_FIRST ? word_if.wordIn[WORD_WIDTH-1-i] : word_if.wordIn[i];
  end

  assign shift_strobe = (state_q == StShift) && bitTick && !word_if.abort;

  always_comb begin
    srEnable         = 1'b0;
    srLoadParallelly = 1'b0;
    case (state_q)
      StLoad: begin
        srEnable         = 1'b1;
        srLoadParallelly = 1'b1;
      end
      StShift: srEnable = shift_strobe;
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    word_d      = word_q;
    // The register captures the pre-shift bit 0 on the strobe edge, so the bit is
    // qualified from the following cycle with the count it was shifted at.
    bit_valid_d = shift_strobe;
    bit_index_d = shift_strobe ? count_q : bit_index_q;
    case (state_q)
      StIdle: begin
        if (word_if.start && !word_if.abort) begin
          word_d  = word_ordered;
          state_d = StLoad;
        end
      end
      StLoad: begin
        count_d = '0;
        state_d = word_if.abort ? StIdle : StShift;
      end
      StShift: begin
        if (word_if.abort) begin
          state_d = StIdle;
        end else if (bitTick) begin
          count_d = count_q + 1'b1;
          if (count_q == LastCount) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    frame_done_d = (state_d == StDone);
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q      <= StIdle;
      count_q      <= '0;
      word_q       <= '0;
      bit_valid_q  <= 1'b0;
      bit_index_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      word_q       <= word_d;
      bit_valid_q  <= bit_valid_d;
      bit_index_q  <= bit_index_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign word_if.ready  = (state_q == StIdle);
  assign word_if.busy   = (state_q != StIdle);
  assign srParallelLoad = word_q;
  assign srShiftRight   = 1'b1;
  assign srSerialLoad   = FILL_BIT;
  assign bitOut         = srSerialOutput;
  assign bitValid       = bit_valid_q;
  assign bitIndex       = bit_index_q;
  assign frameDone      = frame_done_q;

endmodule

// File: tb/tb_shift_frame_sequencer.sv
// Bench for shift_frame_sequencer: LSB-first and MSB-first instances driven in lockstep,
// each feeding a behavioural shift register, checked against a frame-level model.
module tb_shift_frame_sequencer;
  localparam int unsigned W  = 16;
  localparam int unsigned CW = 4;
  localparam int PhIdle = 0, PhLoad = 1, PhShift = 2, PhDone = 3;

  logic         clock   = 1'b0;
  logic         resetN  = 1'b0;
  logic         start   = 1'b0;
  logic         abort   = 1'b0;
  logic         bitTick = 1'b0;
  logic [W-1:0] wordIn  = '0;
  logic         mon_on  = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  shift_frame_sequencer_if #(.WORD_WIDTH(W)) if0 ();
  shift_frame_sequencer_if #(.WORD_WIDTH(W)) if1 ();

  assign if0.start  = start;
  assign if0.abort  = abort;
  assign if0.wordIn = wordIn;
  assign if1.start  = start;
  assign if1.abort  = abort;
  assign if1.wordIn = wordIn;

  logic en0, ld0, shr0, sl0, bo0, bv0, fd0;
  logic en1, ld1, shr1, sl1, bo1, bv1, fd1;
  logic [W-1:0]  pl0, pl1;
  logic [CW-1:0] bi0, bi1;
  logic [W-1:0]  sr0 = '0, sr1 = '0;
  logic          so0 = 1'b0, so1 = 1'b0;

  shift_frame_sequencer #(.WORD_WIDTH(W), .COUNT_WIDTH(CW), .MSB_FIRST(1'b0), .FILL_BIT(1'b0))
  dut0 (
    .clock(clock), .resetN(resetN), .word_if(if0), .bitTick(bitTick),
    .srEnable(en0), .srLoadParallelly(ld0), .srParallelLoad(pl0), .srShiftRight(shr0),
    .srSerialLoad(sl0), .srSerialOutput(so0), .bitOut(bo0), .bitValid(bv0),
    .bitIndex(bi0), .frameDone(fd0)
  );

  shift_frame_sequencer #(.WORD_WIDTH(W), .COUNT_WIDTH(CW), .MSB_FIRST(1'b1), .FILL_BIT(1'b0))
  dut1 (
    .clock(clock), .resetN(resetN), .word_if(if1), .bitTick(bitTick),
    .srEnable(en1), .srLoadParallelly(ld1), .srParallelLoad(pl1), .srShiftRight(shr1),
    .srSerialLoad(sl1), .srSerialOutput(so1), .bitOut(bo1), .bitValid(bv1),
    .bitIndex(bi1), .frameDone(fd1)
  );

  // External right-shifting registers with a registered serial output.
  always @(posedge clock) begin
    if (en0) begin
      if (ld0) sr0 <= pl0;
      else begin
        so0 <= sr0[0];
        sr0 <= {sl0, sr0[W-1:1]};
      end
    end
    if (en1) begin
      if (ld1) sr1 <= pl1;
      else begin
        so1 <= sr1[0];
        sr1 <= {sl1, sr1[W-1:1]};
      end
    end
  end

  // Frame-level model: phase, bits shifted so far, captured word, pending bit qualifier.
  int           m_ph    = PhIdle;
  int           m_cnt   = 0;
  int           m_idx   = 0;
  logic [W-1:0] m_word  = '0;
  logic         m_valid = 1'b0;
  logic         m_done  = 1'b0;

  always @(posedge clock) begin
    if (!resetN) begin
      m_ph <= PhIdle; m_cnt <= 0; m_idx <= 0; m_word <= '0; m_valid <= 1'b0; m_done <= 1'b0;
    end else begin
      m_valid <= (m_ph == PhShift) && bitTick && !abort;
      if ((m_ph == PhShift) && bitTick && !abort) m_idx <= m_cnt;
      m_done <= (m_ph == PhShift) && bitTick && !abort && (m_cnt == W - 1);
      case (m_ph)
        PhIdle: if (start && !abort) begin m_word <= wordIn; m_ph <= PhLoad; end
        PhLoad: begin m_cnt <= 0; m_ph <= abort ? PhIdle : PhShift; end
        PhShift: begin
          if (abort) m_ph <= PhIdle;
          else if (bitTick) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == W - 1) m_ph <= PhDone;
          end
        end
        default: m_ph <= PhIdle;
      endcase
    end
  end

  function automatic logic [W-1:0] rev(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = x[W-1-i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input string t, input int d, input logic rdy, input logic bsy,
                           input logic en, input logic ld, input logic shr, input logic sl,
                           input logic bv, input logic fd, input logic [CW-1:0] bi,
                           input logic bo, input logic [W-1:0] pl);
    check({t, ".ready"}, rdy, m_ph == PhIdle);
    check({t, ".busy"}, bsy, m_ph != PhIdle);
    check({t, ".srEnable"}, en, (m_ph == PhLoad) || ((m_ph == PhShift) && bitTick && !abort));
    check({t, ".srLoadParallelly"}, ld, m_ph == PhLoad);
    check({t, ".srShiftRight"}, shr, 1);
    check({t, ".srSerialLoad"}, sl, 0);
    check({t, ".bitValid"}, bv, m_valid);
    check({t, ".frameDone"}, fd, m_done);
    check({t, ".srParallelLoad"}, pl, (d != 0) ? rev(m_word) : m_word);
    if (m_valid) begin
      check({t, ".bitIndex"}, bi, m_idx);
      check({t, ".bitOut"}, bo, (d != 0) ? m_word[W-1-m_idx] : m_word[m_idx]);
    end
  endtask

  always @(negedge clock) begin
    if (mon_on) begin
      check_dut("d0", 0, if0.ready, if0.busy, en0, ld0, shr0, sl0, bv0, fd0, bi0, bo0, pl0);
      check_dut("d1", 1, if1.ready, if1.busy, en1, ld1, shr1, sl1, bv1, fd1, bi1, bo1, pl1);
    end
  end

  logic          got0[$];
  logic          got1[$];
  logic [CW-1:0] idx1[$];
  int            vcyc[$];
  logic          rq[$];
  int            nen, nen_late, nd, done_cyc;
  int            t1_exp[16] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1};

  // One frame attempt: start in cycle 0 (plus optional extra start pulses s1/s2),
  // bitTick every `period` cycles, optional abort in cycle abort_at.
  task automatic run(input logic [W-1:0] w, input int ncyc, input int period,
                     input int abort_at, input int s1, input int s2);
    got0.delete(); got1.delete(); idx1.delete(); vcyc.delete(); rq.delete();
    nen = 0; nen_late = 0; nd = 0; done_cyc = -1;
    wordIn = w;
    for (int c = 0; c < ncyc; c++) begin
      start   = (c == 0) || (c == s1) || (c == s2);
      abort   = (c == abort_at);
      bitTick = (c % period) == (period - 1);
      @(negedge clock);
      rq.push_back(if0.ready);
      if (en0) begin
        nen++;
        if (abort_at >= 0 && c >= abort_at) nen_late++;
      end
      if (bv0) begin got0.push_back(bo0); vcyc.push_back(c); end
      if (bv1) begin got1.push_back(bo1); idx1.push_back(bi1); end
      if (fd0) begin nd++; done_cyc = c; end
      @(posedge clock); #1;
    end
    start = 1'b0; abort = 1'b0; bitTick = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    mon_on = 1'b1;
    resetN = 1'b1;
    @(negedge clock);
    check("rst_ready", if0.ready, 1);
    check("rst_busy", if0.busy, 0);
    check("rst_srEnable", en0, 0);
    check("rst_bitValid", bv0, 0);
    check("rst_bitIndex", bi0, 0);
    check("rst_frameDone", fd0, 0);
    check("rst_parallel", pl0, 0);
    @(posedge clock); #1;

    // LSB first, bitTick always high
    run(16'hA5C3, 20, 1, -1, -1, -1);
    check("t1_nbits", got0.size(), 16);
    for (int i = 0; i < got0.size() && i < 16; i++) check($sformatf("t1_bit%0d", i), got0[i], t1_exp[i]);
    check("t1_first_valid", vcyc[0], 3);
    check("t1_last_valid", vcyc[vcyc.size()-1], 18);
    check("t1_done_cycle", done_cyc, 18);
    check("t1_ndone", nd, 1);
    check("t1_ready_c19", rq[19], 1);
    check("t1_strobes", nen, 17);

    // bitTick every 4th cycle
    run(16'h00FF, 70, 4, -1, -1, -1);
    check("t2_nbits", got0.size(), 16);
    for (int i = 0; i < got0.size() && i < 16; i++) check($sformatf("t2_bit%0d", i), got0[i], i < 8);
    for (int i = 1; i < vcyc.size(); i++) check($sformatf("t2_space%0d", i), vcyc[i] - vcyc[i-1], 4);
    check("t2_first_valid", vcyc[0], 4);
    check("t2_strobes", nen, 17);
    check("t2_ndone", nd, 1);
    check("t2_done_cycle", done_cyc, 64);

    // MSB-first instance
    run(16'h8000, 20, 1, -1, -1, -1);
    check("t3_nbits", got1.size(), 16);
    for (int i = 0; i < got1.size() && i < 16; i++) begin
      check($sformatf("t3_bit%0d", i), got1[i], i == 0);
      check($sformatf("t3_idx%0d", i), idx1[i], i);
    end
    check("t3_parallel_rev", pl1, 16'h0001);

    // abort in the cycle after the 5th bitValid
    run(16'h5A5A, 16, 1, 8, -1, -1);
    check("t4_5th_idx", idx1[4], 4);
    check("t4_nvalid", vcyc.size(), 6);
    check("t4_late_strobes", nen_late, 0);
    check("t4_ndone", nd, 0);
    check("t4_idle_c9", rq[9], 1);
    run(16'h0001, 20, 1, -1, -1, -1);
    check("t4b_nbits", got0.size(), 16);
    for (int i = 0; i < got0.size() && i < 16; i++) check($sformatf("t4b_bit%0d", i), got0[i], i == 0);
    check("t4b_ndone", nd, 1);
    check("t4b_done_cycle", done_cyc, 18);

    // start pulsed in SHIFT and in DONE, then start with abort in IDLE
    run(16'h1234, 26, 1, -1, 5, 18);
    check("t5_strobes", nen, 17);
    check("t5_ndone", nd, 1);
    check("t5_ready_c25", rq[25], 1);
    run(16'hFFFF, 4, 1, 0, -1, -1);
    check("t5b_strobes", nen, 0);
    check("t5b_ndone", nd, 0);
    check("t5b_ready_c1", rq[1], 1);
    check("t5b_parallel_kept", pl0, 16'h1234);

    // reset in the cycle bit 7 is qualified
    wordIn  = 16'hBEEF;
    bitTick = 1'b1;
    for (int c = 0; c <= 11; c++) begin
      start  = (c == 0);
      resetN = (c != 10);
      @(negedge clock);
      if (c == 10) check("t6_bit7_idx", bi0, 7);
      if (c == 11) begin
        check("t6_ready", if0.ready, 1);
        check("t6_busy", if0.busy, 0);
        check("t6_srEnable", en0, 0);
        check("t6_bitValid", bv0, 0);
        check("t6_bitIndex", bi0, 0);
        check("t6_frameDone", fd0, 0);
        check("t6_parallel0", pl0, 0);
        check("t6_parallel1", pl1, 0);
      end
      @(posedge clock); #1;
    end
    resetN  = 1'b1;
    bitTick = 1'b0;
    run(16'h0F0F, 20, 1, -1, -1, -1);
    check("t6b_ndone", nd, 1);
    check("t6b_nbits", got0.size(), 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
